// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the writeback pipeline always wins, and
// long-latency load responses wait in a small FIFO for idle slots.
module wb_port_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_THREADS  = 8,
  parameter int BITS_THREADS = $clog2(NUM_THREADS),
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        reg_write_w,
  input  logic [4:0]                  rd_w,
  input  logic [BITS_THREADS-1:0]     tid_w,
  input  logic [DATA_WIDTH-1:0]       result_w,
  input  logic                        lr_valid,
  input  logic [4:0]                  lr_rd,
  input  logic [BITS_THREADS-1:0]     lr_tid,
  input  logic [DATA_WIDTH-1:0]       lr_data,
  output logic                        lr_ready,
  output logic                        rf_we,
  output logic [4:0]                  rf_rd,
  output logic [BITS_THREADS-1:0]     rf_tid,
  output logic [DATA_WIDTH-1:0]       rf_wdata,
  output logic                        lr_done_valid,
  output logic [BITS_THREADS-1:0]     lr_done_tid,
  output logic                        bubble_req,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [4:0]              rd;
    logic [BITS_THREADS-1:0] tid;
    logic [DATA_WIDTH-1:0]   data;
  } entry_t;

  entry_t                  mem_q [FIFO_DEPTH];
  entry_t                  head;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic [WW-1:0]           wait_q, wait_d;
  logic                    rf_we_q, rf_we_d;
  logic [4:0]              rf_rd_q, rf_rd_d;
  logic [BITS_THREADS-1:0] rf_tid_q, rf_tid_d;
  logic [DATA_WIDTH-1:0]   rf_wdata_q, rf_wdata_d;
  logic                    lr_done_valid_q, lr_done_valid_d;
  logic [BITS_THREADS-1:0] lr_done_tid_q, lr_done_tid_d;
  logic                    bubble_req_q, bubble_req_d;
  logic                    busy, push, pop;

  // Readiness comes from the registered count only, so a same-cycle pop never
  // frees a slot for a push.
  assign lr_ready = (count_q < CW'(FIFO_DEPTH));
  assign push     = lr_valid && lr_ready;
  assign busy     = reg_write_w && (rd_w != 5'd0);
  assign pop      = !busy && (count_q != '0);
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (pop || count_q == '0)             wait_d = '0;
    else if (wait_q == WW'(STARVE_LIMIT)) wait_d = wait_q;
    else                                  wait_d = wait_q + WW'(1);
    bubble_req_d = (wait_d == WW'(STARVE_LIMIT));
  end

  always_comb begin
    rf_we_d         = 1'b0;
    rf_rd_d         = rf_rd_q;
    rf_tid_d        = rf_tid_q;
    rf_wdata_d      = rf_wdata_q;
    lr_done_valid_d = 1'b0;
    lr_done_tid_d   = lr_done_tid_q;
    if (busy) begin
      rf_we_d    = 1'b1;
      rf_rd_d    = rd_w;
      rf_tid_d   = tid_w;
      rf_wdata_d = result_w;
    end else if (pop) begin
      rf_we_d         = (head.rd != 5'd0);
      rf_rd_d         = head.rd;
      rf_tid_d        = head.tid;
      rf_wdata_d      = head.data;
      lr_done_valid_d = 1'b1;
      lr_done_tid_d   = head.tid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      wait_q          <= '0;
      rf_we_q         <= 1'b0;
      rf_rd_q         <= '0;
      rf_tid_q        <= '0;
      rf_wdata_q      <= '0;
      lr_done_valid_q <= 1'b0;
      lr_done_tid_q   <= '0;
      bubble_req_q    <= 1'b0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      wait_q          <= wait_d;
      rf_we_q         <= rf_we_d;
      rf_rd_q         <= rf_rd_d;
      rf_tid_q        <= rf_tid_d;
      rf_wdata_q      <= rf_wdata_d;
      lr_done_valid_q <= lr_done_valid_d;
      lr_done_tid_q   <= lr_done_tid_d;
      bubble_req_q    <= bubble_req_d;
    end
  end

  // Entry storage needs no reset: the pointers and count decide what is live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{rd: lr_rd, tid: lr_tid, data: lr_data};
  end

  assign rf_we         = rf_we_q;
  assign rf_rd         = rf_rd_q;
  assign rf_tid        = rf_tid_q;
  assign rf_wdata      = rf_wdata_q;
  assign lr_done_valid = lr_done_valid_q;
  assign lr_done_tid   = lr_done_tid_q;
  assign bubble_req    = bubble_req_q;
  assign fifo_count    = count_q;
endmodule
